oam_dma_arbiter: RTL

- Sits between the CPU bus (address, dataOut, dataIn, busWriteEnable) and the single-port synchronous memory used by the CPU bench.
- Owns the DMA source register at FF46. A CPU write to FF46 starts a 160-byte copy from {src,8'h00} to FE00.
- Arbitrates the memory port between the CPU and the DMA engine. Memory read data appears on memDataIn one cycle after the address is presented.

---
 rtl/oam_dma_arbiter_if.sv | 24 ++
 rtl/oam_dma_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus of the OAM DMA arbiter.
// The master modport is the CPU plus memory (the surrounding system); the
// slave modport is the arbiter itself.
interface oam_dma_arbiter_if;
   logic [15:0] cpuAddress;
   logic [7:0]  cpuDataOut;
   logic        cpuWriteEnable;
   logic [7:0]  cpuDataIn;
   logic [15:0] memAddress;
   logic [7:0]  memDataOut;
   logic        memWriteEnable;
   logic [7:0]  memDataIn;
   logic        dmaActive;

   modport master (
      output cpuAddress, cpuDataOut, cpuWriteEnable, memDataIn,
      input  cpuDataIn, memAddress, memDataOut, memWriteEnable, dmaActive
   );

   modport slave (
      input  cpuAddress, cpuDataOut, cpuWriteEnable, memDataIn,
      output cpuDataIn, memAddress, memDataOut, memWriteEnable, dmaActive
   );
endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and memory-port arbiter between the CPU and a single-port
// synchronous memory (one-cycle read latency).
// A CPU write to DMA_REG_ADDR copies DMA_LENGTH bytes from {src,8'h00} to
// OAM_BASE. Optional macro OAM_DMA_CPU_LOCKOUT_EN: when defined, CPU accesses
// below HRAM_BASE are blocked during the copy (reads return FF, writes are
// dropped); when undefined, every CPU memory access wins the port and the
// DMA stalls for that cycle.
module oam_dma_arbiter #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] OAM_BASE     = 16'hFE00,
   parameter int unsigned DMA_LENGTH   = 160,
   parameter logic [15:0] HRAM_BASE    = 16'hFF80
) (
   input  logic               clk,
   input  logic               reset,
   oam_dma_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} state_t;
   typedef enum logic [1:0] {RD_MEM, RD_REG, RD_BLK} rd_src_t;

   localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

   state_t     state_q, state_d;
   rd_src_t    rd_src_q, rd_src_d;
   logic [7:0] src_q, src_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] dma_byte_q, dma_byte_d;
   logic       read_pending_q, read_pending_d;

   logic cpu_is_reg;
   logic reg_write;
   logic dma_bus;
   logic cpu_hram;
   logic cpu_wins;
   logic cpu_blocked;
   logic dma_grant;

   assign cpu_is_reg = (bus.cpuAddress == DMA_REG_ADDR);
   assign reg_write  = cpu_is_reg && bus.cpuWriteEnable;
   assign dma_bus    = (state_q == S_READ) || (state_q == S_WRITE);
   assign cpu_hram   = (bus.cpuAddress >= HRAM_BASE);

`ifdef OAM_DMA_CPU_LOCKOUT_EN
   assign cpu_wins    = dma_bus && !cpu_is_reg && cpu_hram;
   assign cpu_blocked = dma_bus && !cpu_is_reg && !cpu_hram;
`else
   assign cpu_wins    = dma_bus && !cpu_is_reg;
   assign cpu_blocked = 1'b0;
`endif

   // A register write abandons the current DMA cycle, so it never owns the bus.
   assign dma_grant = dma_bus && !cpu_wins && !reg_write;

   // State and datapath registers, asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         rd_src_q       <= RD_REG;
         src_q          <= '0;
         idx_q          <= '0;
         dma_byte_q     <= '0;
         read_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_src_q       <= rd_src_d;
         src_q          <= src_d;
         idx_q          <= idx_d;
         dma_byte_q     <= dma_byte_d;
         read_pending_q <= read_pending_d;
      end
   end

   // Next-state logic: sequencing, register writes and read-data capture.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_START: state_d = S_READ;
         S_READ:  if (dma_grant) state_d = S_WRITE;
         S_WRITE: if (dma_grant) begin
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == LAST_IDX) ? S_IDLE : S_READ;
         end
         default: state_d = state_q;
      endcase
      if (reg_write) begin
         src_d   = bus.cpuDataOut;
         idx_d   = '0;
         state_d = S_START;
      end
      read_pending_d = dma_grant && (state_q == S_READ);
      // Read data is captured the cycle after READ even if the CPU stole the port.
      dma_byte_d     = read_pending_q ? bus.memDataIn : dma_byte_q;
      if (cpu_is_reg) begin
         rd_src_d = RD_REG;
      end else if (cpu_blocked) begin
         rd_src_d = RD_BLK;
      end else begin
         rd_src_d = RD_MEM;
      end
   end

   // Output logic: memory port mux, busy flag and registered read-data select.
   always_comb begin
      bus.memAddress     = bus.cpuAddress;
      bus.memWriteEnable = bus.cpuWriteEnable;
      bus.memDataOut     = bus.cpuDataOut;
      if (dma_grant) begin
         if (state_q == S_READ) begin
            bus.memAddress     = {src_q, idx_q};
            bus.memWriteEnable = 1'b0;
         end else begin
            bus.memAddress     = OAM_BASE + {8'h00, idx_q};
            bus.memWriteEnable = 1'b1;
            bus.memDataOut     = read_pending_q ? bus.memDataIn : dma_byte_q;
         end
      end else if (cpu_is_reg) begin
         bus.memWriteEnable = 1'b0;
      end
      if (!reset) begin
         bus.memWriteEnable = 1'b0;
         bus.memDataOut     = '0;
      end
      bus.dmaActive = (state_q != S_IDLE);
      unique case (rd_src_q)
         RD_MEM:  bus.cpuDataIn = bus.memDataIn;
         RD_REG:  bus.cpuDataIn = src_q;
         default: bus.cpuDataIn = 8'hFF;
      endcase
   end

endmodule
